// File: rtl/i281_register_file_if.sv
// i281 register file bus: writeback port, two operand read ports and
// the observation outputs (live register words and committed-write count).
// master = writeback stage / operand consumer, slave = the register file.
interface i281_register_file_if #(
    parameter int N = 16
);
    logic         stall;
    logic         writeEnable;
    logic [1:0]   writeSelect;
    logic [N-1:0] writeData;
    logic [1:0]   readSelectA;
    logic [1:0]   readSelectB;
    logic [N-1:0] readDataA;
    logic [N-1:0] readDataB;
    logic [N-1:0] regA;
    logic [N-1:0] regB;
    logic [N-1:0] regC;
    logic [N-1:0] regD;
    logic [15:0]  writeCount;

    modport master (
        output stall, writeEnable, writeSelect, writeData, readSelectA, readSelectB,
        input  readDataA, readDataB, regA, regB, regC, regD, writeCount
    );

    modport slave (
        input  stall, writeEnable, writeSelect, writeData, readSelectA, readSelectB,
        output readDataA, readDataB, regA, regB, regC, regD, writeCount
    );
endinterface

// File: rtl/i281_register_file.sv
// i281 four-entry general-purpose register file (A, B, C, D).
// One clocked write port, two combinational read ports, every register word
// exposed for the operand muxes and the visualizer, plus a wrapping count of
// committed writes.
// Optional feature: define REGFILE_BYPASS_EN to forward the writeback value
// to a read port whose select matches the register being written this cycle.
module i281_register_file #(
    parameter int           N       = 16,
    parameter logic [N-1:0] RST_VAL = '0
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    i281_register_file_if.slave    bus
);

    logic [N-1:0] regFileQ [4];
    logic [N-1:0] regFileD [4];
    logic [15:0]  writeCountQ;
    logic [15:0]  writeCountD;
    logic         commit;
    logic [N-1:0] readDataA;
    logic [N-1:0] readDataB;

    // A write commits only when enabled, not stalled and not being reset.
    assign commit = bus.writeEnable && !bus.stall && !rst_i;

    // Next-state: only the selected register takes the write data; an
    // unresolvable select matches no case item, so nothing is written.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            regFileD[i] = regFileQ[i];
        end
        writeCountD = writeCountQ;
        if (commit) begin
            case (bus.writeSelect)
                2'd0: begin
                    regFileD[0] = bus.writeData;
                    writeCountD = writeCountQ + 16'd1;
                end
                2'd1: begin
                    regFileD[1] = bus.writeData;
                    writeCountD = writeCountQ + 16'd1;
                end
                2'd2: begin
                    regFileD[2] = bus.writeData;
                    writeCountD = writeCountQ + 16'd1;
                end
                2'd3: begin
                    regFileD[3] = bus.writeData;
                    writeCountD = writeCountQ + 16'd1;
                end
                default: begin
                    writeCountD = writeCountQ;
                end
            endcase
        end
    end

    // Register state and write counter, synchronous reset wins over any write.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < 4; i++) begin
                regFileQ[i] <= RST_VAL;
            end
            writeCountQ <= 16'd0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                regFileQ[i] <= regFileD[i];
            end
            writeCountQ <= writeCountD;
        end
    end

`ifdef REGFILE_BYPASS_EN
    // Read ports forward the in-flight write when the selects match.
    always_comb begin
        readDataA = regFileQ[bus.readSelectA];
        readDataB = regFileQ[bus.readSelectB];
        if (commit && (bus.readSelectA == bus.writeSelect)) begin
            readDataA = bus.writeData;
        end
        if (commit && (bus.readSelectB == bus.writeSelect)) begin
            readDataB = bus.writeData;
        end
    end
`else
    // Read ports reflect stored state only; a write shows up after the edge.
    always_comb begin
        readDataA = regFileQ[bus.readSelectA];
        readDataB = regFileQ[bus.readSelectB];
    end
`endif

    assign bus.readDataA  = readDataA;
    assign bus.readDataB  = readDataB;
    assign bus.regA       = regFileQ[0];
    assign bus.regB       = regFileQ[1];
    assign bus.regC       = regFileQ[2];
    assign bus.regD       = regFileQ[3];
    assign bus.writeCount = writeCountQ;

endmodule

// File: tb/tb_i281_register_file.sv
// Directed testbench for i281_register_file: reset, per-register writes,
// stall hold, read-during-write (both builds), equal read selects,
// write-counter wrap and reset during a pending write.
module tb_i281_register_file;

    logic clk;
    logic rst;
    int   passCount;
    int   checkCount;

    i281_register_file_if #(.N(16)) bus ();

    i281_register_file #(.N(16), .RST_VAL(16'h0000)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one rising edge, then settle 1 time unit away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    endtask

    // Drive every master-side input in one go.
    task automatic applyStimulus(input logic we, input logic st, input logic [1:0] ws,
                                 input logic [15:0] wd, input logic [1:0] rsA,
                                 input logic [1:0] rsB);
        bus.writeEnable = we;
        bus.stall       = st;
        bus.writeSelect = ws;
        bus.writeData   = wd;
        bus.readSelectA = rsA;
        bus.readSelectB = rsB;
    endtask

    // Directed sequence with hand-computed expectations.
    initial begin
        logic [15:0] rdwExpected;
        passCount  = 0;
        checkCount = 0;

        // Reset with a write pending: reset must win.
        rst = 1'b1;
        applyStimulus(1'b1, 1'b0, 2'd0, 16'h1234, 2'd0, 2'd1);
        tick();
        checkOutput("reset regA", bus.regA, 16'h0000);
        checkOutput("reset regB", bus.regB, 16'h0000);
        checkOutput("reset regC", bus.regC, 16'h0000);
        checkOutput("reset regD", bus.regD, 16'h0000);
        checkOutput("reset count", bus.writeCount, 16'h0000);
        checkOutput("reset readA", bus.readDataA, 16'h0000);
        checkOutput("reset readB", bus.readDataB, 16'h0000);

        // Write each register on consecutive edges.
        rst = 1'b0;
        applyStimulus(1'b1, 1'b0, 2'd0, 16'h1111, 2'd0, 2'd1);
        tick();
        applyStimulus(1'b1, 1'b0, 2'd1, 16'h2222, 2'd0, 2'd1);
        tick();
        applyStimulus(1'b1, 1'b0, 2'd2, 16'h3333, 2'd0, 2'd1);
        tick();
        applyStimulus(1'b1, 1'b0, 2'd3, 16'h4444, 2'd0, 2'd1);
        tick();
        applyStimulus(1'b0, 1'b0, 2'd0, 16'h0000, 2'd2, 2'd3);
        #1;
        checkOutput("write regA", bus.regA, 16'h1111);
        checkOutput("write regB", bus.regB, 16'h2222);
        checkOutput("write regC", bus.regC, 16'h3333);
        checkOutput("write regD", bus.regD, 16'h4444);
        checkOutput("write readA sel2", bus.readDataA, 16'h3333);
        checkOutput("write readB sel3", bus.readDataB, 16'h4444);
        checkOutput("write count", bus.writeCount, 16'd4);

        // Stall suppresses the write; dropping it lets the write through.
        applyStimulus(1'b1, 1'b1, 2'd1, 16'hBEEF, 2'd2, 2'd3);
        tick();
        checkOutput("stall regB held", bus.regB, 16'h2222);
        checkOutput("stall count held", bus.writeCount, 16'd4);
        bus.stall = 1'b0;
        tick();
        bus.writeEnable = 1'b0;
        #1;
        checkOutput("unstall regB", bus.regB, 16'hBEEF);
        checkOutput("unstall count", bus.writeCount, 16'd5);

        // Read-during-write on port A.
`ifdef REGFILE_BYPASS_EN
        rdwExpected = 16'hCAFE;
`else
        rdwExpected = 16'h1111;
`endif
        applyStimulus(1'b1, 1'b0, 2'd0, 16'hCAFE, 2'd0, 2'd3);
        #1;
        checkOutput("rdw pre-edge readA", bus.readDataA, rdwExpected);
        checkOutput("rdw pre-edge regA", bus.regA, 16'h1111);
        checkOutput("rdw pre-edge readB", bus.readDataB, 16'h4444);
        tick();
        bus.writeEnable = 1'b0;
        #1;
        checkOutput("rdw post-edge readA", bus.readDataA, 16'hCAFE);
        checkOutput("rdw post-edge regA", bus.regA, 16'hCAFE);
        checkOutput("rdw count", bus.writeCount, 16'd6);

        // Stall disables forwarding in both builds.
        applyStimulus(1'b1, 1'b1, 2'd0, 16'h1357, 2'd0, 2'd0);
        #1;
        checkOutput("stall no-forward readA", bus.readDataA, 16'hCAFE);
        tick();
        applyStimulus(1'b0, 1'b0, 2'd0, 16'h0000, 2'd1, 2'd1);
        #1;
        checkOutput("stalled write regA", bus.regA, 16'hCAFE);

        // Equal read selects return the same word.
        checkOutput("same-sel readA", bus.readDataA, 16'hBEEF);
        checkOutput("same-sel readB", bus.readDataB, 16'hBEEF);

        // Counter wrap: 6 + 65529 = FFFF, one more wraps to 0000.
        applyStimulus(1'b1, 1'b0, 2'd0, 16'hCAFE, 2'd0, 2'd1);
        repeat (65529) tick();
        checkOutput("count FFFF", bus.writeCount, 16'hFFFF);
        tick();
        bus.writeEnable = 1'b0;
        #1;
        checkOutput("count wrap", bus.writeCount, 16'h0000);
        checkOutput("wrap regA", bus.regA, 16'hCAFE);
        checkOutput("wrap regB", bus.regB, 16'hBEEF);
        checkOutput("wrap regC", bus.regC, 16'h3333);
        checkOutput("wrap regD", bus.regD, 16'h4444);

        // Mid-run reset discards the concurrent write.
        applyStimulus(1'b0, 1'b0, 2'd0, 16'h0000, 2'd0, 2'd1);
        tick();
        checkOutput("idle count", bus.writeCount, 16'h0000);
        rst = 1'b1;
        applyStimulus(1'b1, 1'b0, 2'd3, 16'hFFFF, 2'd3, 2'd0);
        tick();
        checkOutput("midreset regA", bus.regA, 16'h0000);
        checkOutput("midreset regB", bus.regB, 16'h0000);
        checkOutput("midreset regC", bus.regC, 16'h0000);
        checkOutput("midreset regD", bus.regD, 16'h0000);
        checkOutput("midreset readA", bus.readDataA, 16'h0000);

        // Write resumes as soon as reset drops.
        rst = 1'b0;
        tick();
        bus.writeEnable = 1'b0;
        #1;
        checkOutput("resume regD", bus.regD, 16'hFFFF);
        checkOutput("resume count", bus.writeCount, 16'd1);
        checkOutput("resume readA", bus.readDataA, 16'hFFFF);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
